// File: rtl/tape_controller_pkg.sv
// Shared definitions for the tape controller and the core that drives it.
//   tc_state_e : controller FSM state encoding
//   BlankSym   : value held by every tape cell after reset
package tape_controller_pkg;

    typedef enum logic [1:0] {
        StRead  = 2'd0,
        StValid = 2'd1,
        StHold  = 2'd2,
        StFault = 2'd3
    } tc_state_e;

    localparam int unsigned BlankSym = 0;

endpackage

// File: rtl/tape_controller_tape_ram.sv
// Tape storage: one write port, a registered read at the head position and a
// registered debug (dump) read. Every cell is re-blanked by reset.
//   clk_i / rst_ni     : clock, asynchronous active-low reset
//   we_i, waddr_i,
//   wdata_i            : write port (step write or preload)
//   rd_en_i, rd_addr_i : head read; rd_data_o holds its value while rd_en_i=0
//   dump_addr_i        : debug address, dump_data_o valid one cycle later
module tape_ram import tape_controller_pkg::*; #(
    parameter int unsigned  SYM_W = 3,
    parameter int unsigned  DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [SYM_W-1:0] wdata_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [SYM_W-1:0] rd_data_o,
    input  logic [AW-1:0]    dump_addr_i,
    output logic [SYM_W-1:0] dump_data_o
);

    logic [SYM_W-1:0] mem_q [DEPTH];
    logic [SYM_W-1:0] rd_data_q;
    logic [SYM_W-1:0] dump_data_q;

    // Reads sample the array before this edge's write lands, so a same-cycle
    // write to the read address returns the old contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= SYM_W'(BlankSym);
            end
            rd_data_q   <= SYM_W'(BlankSym);
            dump_data_q <= SYM_W'(BlankSym);
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            if (rd_en_i) begin
                rd_data_q <= mem_q[rd_addr_i];
            end
            dump_data_q <= mem_q[dump_addr_i];
        end
    end

    assign rd_data_o   = rd_data_q;
    assign dump_data_o = dump_data_q;

endmodule

// File: rtl/tape_controller.sv
// Tape controller: presents the symbol under the head to a stepping core,
// accepts steps (write symbol, move head), supports a hold/preload mode and a
// sticky fault when the head would leave the tape in bounded mode.
//   clk_i / rst_ni              : clock, asynchronous active-low reset
//   sym_o, sym_valid_o          : symbol under head and its qualifier
//   step_valid_i, step_ready_o  : step handshake
//   new_sym_i, direction_i      : symbol to write, 1 = right / 0 = left
//   hold_i                      : pause stepping and open the load port
//   load_en_i/addr_i/data_i     : preload write, honoured only while holding
//   dump_addr_i, dump_data_o    : debug read, one cycle latency
//   head_pos_o, edge_fault_o    : head position, sticky bound fault
module tape_controller import tape_controller_pkg::*; #(
    parameter int unsigned  SYM_W      = 3,
    parameter int unsigned  TAPE_DEPTH = 64,
    parameter int unsigned  HEAD_INIT  = 32,
    parameter int unsigned  BOUND_MODE = 0,
    localparam int unsigned AW         = $clog2(TAPE_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [SYM_W-1:0] sym_o,
    output logic             sym_valid_o,
    input  logic             step_valid_i,
    output logic             step_ready_o,
    input  logic [SYM_W-1:0] new_sym_i,
    input  logic             direction_i,
    input  logic             hold_i,
    input  logic             load_en_i,
    input  logic [AW-1:0]    load_addr_i,
    input  logic [SYM_W-1:0] load_data_i,
    input  logic [AW-1:0]    dump_addr_i,
    output logic [SYM_W-1:0] dump_data_o,
    output logic [AW-1:0]    head_pos_o,
    output logic             edge_fault_o
);

    tc_state_e     state_q;
    logic [AW-1:0] head_q;
    logic          sym_valid_q;
    logic          step_ready_q;
    logic          edge_fault_q;

    logic             accept;
    logic             off_end;
    logic [AW-1:0]    head_next;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [SYM_W-1:0] ram_wdata;

    always_comb begin
        accept    = (state_q == StValid) && step_valid_i;
        // Power-of-two depth makes AW-bit wraparound the modulo arithmetic.
        head_next = direction_i ? head_q + AW'(1) : head_q - AW'(1);
        off_end   = direction_i ? (head_q == AW'(TAPE_DEPTH - 1)) : (head_q == '0);
        // Step writes and preloads live in different states, so one port suffices.
        ram_we    = accept || ((state_q == StHold) && load_en_i);
        ram_waddr = accept ? head_q : load_addr_i;
        ram_wdata = accept ? new_sym_i : load_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StRead;
            head_q       <= AW'(HEAD_INIT);
            sym_valid_q  <= 1'b0;
            step_ready_q <= 1'b0;
            edge_fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRead: begin
                    if (hold_i) begin
                        state_q <= StHold;
                    end else begin
                        state_q      <= StValid;
                        sym_valid_q  <= 1'b1;
                        step_ready_q <= 1'b1;
                    end
                end
                StValid: begin
                    if (step_valid_i) begin
                        sym_valid_q  <= 1'b0;
                        step_ready_q <= 1'b0;
                        if ((BOUND_MODE != 0) && off_end) begin
                            // The symbol is still written; only the move is refused.
                            edge_fault_q <= 1'b1;
                            state_q      <= StFault;
                        end else begin
                            head_q  <= head_next;
                            state_q <= StRead;
                        end
                    end else if (hold_i) begin
                        sym_valid_q  <= 1'b0;
                        step_ready_q <= 1'b0;
                        state_q      <= StHold;
                    end
                end
                StHold: begin
                    if (!hold_i) begin
                        state_q <= StRead;
                    end
                end
                StFault: begin
                    state_q <= StFault;
                end
                default: begin
                    state_q <= StRead;
                end
            endcase
        end
    end

    tape_ram #(
        .SYM_W (SYM_W),
        .DEPTH (TAPE_DEPTH)
    ) u_tape_ram (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .we_i        (ram_we),
        .waddr_i     (ram_waddr),
        .wdata_i     (ram_wdata),
        .rd_en_i     (state_q == StRead),
        .rd_addr_i   (head_q),
        .rd_data_o   (sym_o),
        .dump_addr_i (dump_addr_i),
        .dump_data_o (dump_data_o)
    );

    assign sym_valid_o  = sym_valid_q;
    assign step_ready_o = step_ready_q;
    assign head_pos_o   = head_q;
    assign edge_fault_o = edge_fault_q;

endmodule

// File: tb/tb_tape_controller.sv
// Bench for tape_controller: three instances sharing stimulus (wrapping from
// the middle, wrapping from the top cell, bounded from cell 0), checked every
// cycle against a behavioural tape model, plus a directed vector table and
// hand-written edge/fault/reset sequences.
module tb_tape_controller;

    localparam int unsigned SW    = 4;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AWB   = 6;
    localparam int          NDUT  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           step_valid, direction, hold, load_en;
    logic [SW-1:0]  new_sym, load_data;
    logic [AWB-1:0] load_addr, dump_addr;

    logic [SW-1:0]  sym_w      [NDUT];
    logic           valid_w    [NDUT];
    logic           ready_w    [NDUT];
    logic [SW-1:0]  dump_w     [NDUT];
    logic [AWB-1:0] head_w     [NDUT];
    logic           fault_w    [NDUT];

    tape_controller #(.SYM_W(SW), .TAPE_DEPTH(DEPTH), .HEAD_INIT(32), .BOUND_MODE(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .sym_o(sym_w[0]), .sym_valid_o(valid_w[0]),
        .step_valid_i(step_valid), .step_ready_o(ready_w[0]), .new_sym_i(new_sym),
        .direction_i(direction), .hold_i(hold), .load_en_i(load_en), .load_addr_i(load_addr),
        .load_data_i(load_data), .dump_addr_i(dump_addr), .dump_data_o(dump_w[0]),
        .head_pos_o(head_w[0]), .edge_fault_o(fault_w[0]));

    tape_controller #(.SYM_W(SW), .TAPE_DEPTH(DEPTH), .HEAD_INIT(63), .BOUND_MODE(0)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .sym_o(sym_w[1]), .sym_valid_o(valid_w[1]),
        .step_valid_i(step_valid), .step_ready_o(ready_w[1]), .new_sym_i(new_sym),
        .direction_i(direction), .hold_i(hold), .load_en_i(load_en), .load_addr_i(load_addr),
        .load_data_i(load_data), .dump_addr_i(dump_addr), .dump_data_o(dump_w[1]),
        .head_pos_o(head_w[1]), .edge_fault_o(fault_w[1]));

    tape_controller #(.SYM_W(SW), .TAPE_DEPTH(DEPTH), .HEAD_INIT(0), .BOUND_MODE(1)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .sym_o(sym_w[2]), .sym_valid_o(valid_w[2]),
        .step_valid_i(step_valid), .step_ready_o(ready_w[2]), .new_sym_i(new_sym),
        .direction_i(direction), .hold_i(hold), .load_en_i(load_en), .load_addr_i(load_addr),
        .load_data_i(load_data), .dump_addr_i(dump_addr), .dump_data_o(dump_w[2]),
        .head_pos_o(head_w[2]), .edge_fault_o(fault_w[2]));

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model: a tape array, a head index and a few phase flags.
    int m_tape  [NDUT][DEPTH];
    int m_head  [NDUT];
    int m_sym   [NDUT];
    int m_dump  [NDUT];
    bit m_valid [NDUT];
    bit m_read  [NDUT];
    bit m_hold  [NDUT];
    bit m_fault [NDUT];

    function automatic int init_of(input int i);
        case (i)
            0:       return 32;
            1:       return 63;
            default: return 0;
        endcase
    endfunction

    function automatic bit bounded(input int i);
        return (i == 2);
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %0d, want %0d", name, i, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            for (int a = 0; a < DEPTH; a++) m_tape[i][a] = 0;
            m_head[i]  = init_of(i);
            m_sym[i]   = 0;
            m_dump[i]  = 0;
            m_valid[i] = 0;
            m_read[i]  = 1;
            m_hold[i]  = 0;
            m_fault[i] = 0;
        end
    endtask

    // One clock edge of the model, using the inputs that were sampled at it.
    task automatic model_edge();
        int d;
        int t;
        for (int i = 0; i < NDUT; i++) begin
            d = m_tape[i][dump_addr];
            if (m_fault[i]) begin
                // frozen until reset
            end else if (m_read[i]) begin
                m_sym[i]  = m_tape[i][m_head[i]];
                m_read[i] = 0;
                if (hold) m_hold[i] = 1;
                else      m_valid[i] = 1;
            end else if (m_hold[i]) begin
                if (load_en) m_tape[i][load_addr] = int'(load_data);
                if (!hold) begin
                    m_hold[i] = 0;
                    m_read[i] = 1;
                end
            end else if (step_valid) begin
                m_tape[i][m_head[i]] = int'(new_sym);
                m_valid[i] = 0;
                t = m_head[i] + (direction ? 1 : -1);
                if ((t < 0 || t >= int'(DEPTH)) && bounded(i)) begin
                    m_fault[i] = 1;
                end else begin
                    m_head[i] = (t + int'(DEPTH)) % int'(DEPTH);
                    m_read[i] = 1;
                end
            end else if (hold) begin
                m_valid[i] = 0;
                m_hold[i]  = 1;
            end
            m_dump[i] = d;
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < NDUT; i++) begin
            check("sym_valid", i, 32'(valid_w[i]), int'(m_valid[i]));
            check("step_ready", i, 32'(ready_w[i]), int'(m_valid[i]));
            check("sym", i, 32'(sym_w[i]), m_sym[i]);
            check("head_pos", i, 32'(head_w[i]), m_head[i]);
            check("edge_fault", i, 32'(fault_w[i]), int'(m_fault[i]));
            check("dump_data", i, 32'(dump_w[i]), m_dump[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        check_model();
    endtask

    task automatic idle_inputs();
        step_valid = 0; new_sym = '0; direction = 0; hold = 0;
        load_en = 0; load_addr = '0; load_data = '0; dump_addr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        #1;
        model_reset();
        check_model();
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        bit stv; int ns; bit dir; bit hld; bit ld; int la; int ldd; int da;
        bit e_valid; int e_sym; int e_head; int e_dump;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit stv, int ns, bit dir, bit hld, bit ld, int la, int ldd,
                                int da, bit ev, int es, int eh, int ed);
        vec_t v;
        v.stv = stv; v.ns = ns; v.dir = dir; v.hld = hld; v.ld = ld; v.la = la; v.ldd = ldd;
        v.da = da; v.e_valid = ev; v.e_sym = es; v.e_head = eh; v.e_dump = ed;
        return v;
    endfunction

    initial begin
        bit bias;
        rst_n = 0;
        idle_inputs();
        model_reset();

        // Directed table on dut0 (head 32, wrapping); outputs expected after each edge.
        vt.push_back(mk(0, 0, 0, 0, 0,  0,  0, 0,  1,  0, 32,  0)); // first READ
        vt.push_back(mk(1, 5, 1, 0, 0,  0,  0, 32, 0,  0, 33,  0)); // step right, old dump
        vt.push_back(mk(0, 0, 0, 0, 0,  0,  0, 32, 1,  0, 33,  5));
        vt.push_back(mk(1, 2, 0, 0, 0,  0,  0, 33, 0,  0, 32,  0)); // step left
        vt.push_back(mk(0, 0, 0, 0, 0,  0,  0, 32, 1,  5, 32,  5));
        vt.push_back(mk(0, 0, 0, 0, 0,  0,  0, 33, 1,  5, 32,  2));
        vt.push_back(mk(0, 0, 0, 1, 0,  0,  0, 32, 0,  5, 32,  5)); // enter HOLD
        vt.push_back(mk(0, 0, 0, 1, 1, 32, 10, 32, 0,  5, 32,  5)); // preload
        vt.push_back(mk(0, 0, 0, 1, 0,  0,  0, 32, 0,  5, 32, 10));
        vt.push_back(mk(0, 0, 0, 0, 0,  0,  0, 32, 0,  5, 32, 10)); // release
        vt.push_back(mk(0, 0, 0, 0, 0,  0,  0, 32, 1, 10, 32, 10));
        vt.push_back(mk(0, 0, 0, 0, 1,  5,  9, 5,  1, 10, 32,  0)); // load outside HOLD
        vt.push_back(mk(0, 0, 0, 0, 0,  0,  0, 5,  1, 10, 32,  0));
        vt.push_back(mk(1, 3, 1, 1, 0,  0,  0, 33, 0, 10, 33,  2)); // step wins over hold
        vt.push_back(mk(0, 0, 0, 1, 0,  0,  0, 33, 0,  2, 33,  2));
        vt.push_back(mk(0, 0, 0, 0, 0,  0,  0, 32, 0,  2, 33,  3));
        vt.push_back(mk(0, 0, 0, 0, 0,  0,  0, 32, 1,  2, 33,  3));

        do_reset();
        foreach (vt[k]) begin
            step_valid = vt[k].stv; new_sym = SW'(vt[k].ns); direction = vt[k].dir;
            hold = vt[k].hld; load_en = vt[k].ld; load_addr = AWB'(vt[k].la);
            load_data = SW'(vt[k].ldd); dump_addr = AWB'(vt[k].da);
            tick();
            check("vec_valid", 0, 32'(valid_w[0]), int'(vt[k].e_valid));
            check("vec_sym", 0, 32'(sym_w[0]), vt[k].e_sym);
            check("vec_head", 0, 32'(head_w[0]), vt[k].e_head);
            check("vec_dump", 0, 32'(dump_w[0]), vt[k].e_dump);
        end

        // Wrap from the top cell and back on dut1.
        do_reset();
        tick();
        step_valid = 1; new_sym = 4'd7; direction = 1;
        tick();
        idle_inputs();
        check("wrap_right_head", 1, 32'(head_w[1]), 0);
        dump_addr = 6'd63;
        tick();
        check("wrap_tape63", 1, 32'(dump_w[1]), 7);
        check("wrap_valid", 1, 32'(valid_w[1]), 1);
        step_valid = 1; new_sym = 4'd1; direction = 0;
        tick();
        idle_inputs();
        check("wrap_left_head", 1, 32'(head_w[1]), 63);

        // Bounded fault on dut2: leftward step from cell 0.
        do_reset();
        tick();
        step_valid = 1; new_sym = 4'd4; direction = 0;
        tick();
        check("fault_set", 2, 32'(fault_w[2]), 1);
        check("fault_head", 2, 32'(head_w[2]), 0);
        check("fault_valid", 2, 32'(valid_w[2]), 0);
        for (int n = 0; n < 10; n++) begin
            step_valid = 1'($urandom); direction = 1'($urandom); hold = 1'($urandom);
            load_en = 1; load_addr = '0; load_data = SW'($urandom); new_sym = SW'($urandom);
            dump_addr = '0;
            tick();
            check("fault_frozen_valid", 2, 32'(valid_w[2]), 0);
            check("fault_frozen_ready", 2, 32'(ready_w[2]), 0);
            check("fault_tape0", 2, 32'(dump_w[2]), 4);
        end

        // Reset while a step is being presented: nothing written, tape blank.
        do_reset();
        tick();
        step_valid = 1; new_sym = 4'd5; direction = 1;
        tick();
        idle_inputs();
        tick();
        step_valid = 1; new_sym = 4'd7; direction = 1;
        do_reset();
        for (int a = 0; a < int'(DEPTH); a++) begin
            dump_addr = AWB'(a);
            tick();
            for (int i = 0; i < NDUT; i++) check("reblank", i, 32'(dump_w[i]), 0);
        end
        check("reset_head", 0, 32'(head_w[0]), 32);

        // Random traffic against the model, with occasional resets.
        do_reset();
        bias = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 256 == 0) bias = ~bias;
            step_valid = ($urandom_range(0, 3) != 0);
            new_sym    = SW'($urandom);
            direction  = ($urandom_range(0, 3) != 0) ^ bias;
            hold       = ($urandom_range(0, 7) == 0);
            load_en    = 1'($urandom);
            load_addr  = AWB'($urandom);
            load_data  = SW'($urandom);
            dump_addr  = AWB'($urandom);
            if ($urandom_range(0, 199) == 0) do_reset();
            else tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tape_controller.md
TAPE_CONTROLLER -- requirements
Module: tape_controller

Interface
REQ-001 SHALL have parameter SYM_W, default 3, symbol width in bits.
REQ-002 SHALL have parameter TAPE_DEPTH, default 64, number of tape cells (>=2, power of two); AW = clog2(TAPE_DEPTH).
REQ-003 SHALL have parameter HEAD_INIT, default 32, head position after reset.
REQ-004 SHALL have parameter BOUND_MODE, default 0; 0 = head wraps at tape ends, 1 = moving off an end is a fault.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clock  in  1  rising-edge clock; reset  in  1  asynchronous active-low reset.
REQ-006 SHALL have sym  out  SYM_W  symbol under head; sym_valid  out  1  sym is valid.
REQ-007 SHALL have step_valid  in  1  core presents a step; step_ready  out  1  step accepted this cycle if step_valid.
REQ-008 SHALL have new_sym  in  SYM_W  symbol to write at head; direction  in  1  1 = right (+1), 0 = left (-1).
REQ-009 SHALL have hold  in  1  pause stepping, enable load port.
REQ-010 SHALL have load_en  in  1, load_addr  in  AW, load_data  in  SYM_W  tape preload write.
REQ-011 SHALL have dump_addr  in  AW, dump_data  out  SYM_W  debug read port.
REQ-012 SHALL have head_pos  out  AW  current head position; edge_fault  out  1  sticky bound fault.

Function
REQ-013 SHALL implement FSM states READ, VALID, HOLD, FAULT.
REQ-014 READ: one cycle; register tape[head_pos] into sym; next state HOLD if hold=1, else VALID.
REQ-015 VALID: sym_valid=1, step_ready=1; on step_valid=1, write new_sym to tape[head_pos], update head, next READ (or FAULT per REQ-018); on step_valid=0 and hold=1, next HOLD; otherwise stay.
REQ-016 Accepted-step latency: sym_valid deasserts the cycle after acceptance and reasserts exactly 2 cycles after the accepting edge.
REQ-017 BOUND_MODE=0: head at TAPE_DEPTH-1 moving right wraps to 0; head at 0 moving left wraps to TAPE_DEPTH-1; all head arithmetic modulo TAPE_DEPTH.
REQ-018 BOUND_MODE=1: a step moving off either end SHALL still write new_sym, leave head unchanged, set edge_fault, and enter FAULT.
REQ-019 FAULT: sym_valid=0, step_ready=0, tape and head frozen, load ignored; exit only by reset.
REQ-020 HOLD: sym_valid=0, step_ready=0; load_en=1 writes load_data to tape[load_addr]; when hold=0, next READ.
REQ-021 load_en outside HOLD SHALL be ignored.
REQ-022 step_valid and hold both 1 in VALID: the step is accepted first; hold is honoured at the next READ.
REQ-023 dump_data SHALL equal tape[dump_addr] one cycle after sampling dump_addr, in all states; a same-cycle write to that address returns the old value.
REQ-024 sym SHALL hold its last value outside VALID; only sym_valid qualifies it.

Reset
REQ-025 On reset low: state READ, sym=0, sym_valid=0, step_ready=0, head_pos=HEAD_INIT, edge_fault=0, dump_data=0, all tape cells=0 (blank).
REQ-026 Reset asserted mid-step SHALL abandon the step without a partial write; tape is re-blanked.

Structure
REQ-027 State encoding and the blank-symbol constant SHALL live in a shared package used by the core and this block.
REQ-028 The tape array with its write port, synchronous head read and dump read SHALL be a sub-module tape_ram; FSM and head logic stay in tape_controller.

Verification
REQ-029 Reset release, defaults, step_valid=0 -> sym_valid=1 on 2nd edge, sym=0, head_pos=32.
REQ-030 Steps (new_sym=5, dir=1) then (new_sym=2, dir=0) -> head 32->33->32; sym=5 after 2nd step; dump_addr=33 gives 0, 32 gives 5.
REQ-031 BOUND_MODE=0, HEAD_INIT=63, step dir=1 new_sym=7 -> head_pos=0, tape[63]=7; then dir=0 from 0 -> head_pos=63.
REQ-032 BOUND_MODE=1, HEAD_INIT=0, step dir=0 new_sym=4 -> tape[0]=4, head_pos=0, edge_fault=1, sym_valid=0 for all following cycles until reset.
REQ-033 hold=1, load 10->addr 32 (SYM_W=4), release hold -> sym=10 two cycles after release; load_en with hold=0 -> tape unchanged.
REQ-034 reset pulsed low while step_valid=1 in VALID -> no write, head_pos=HEAD_INIT, all dump reads 0.
